pal_upload: RTL and testbench

- Bus-master companion to the palette RAM chip: drives the chip's CPU-side write port (G, MWR, A, DIN) in place of the CPU.
- Accepts packed 15-bit RGB palette entries through a valid/ready stream and buffers them in a small FIFO.
- Writes each entry as three component writes: red bank, then green bank, then blue bank.
- Starts new entries only while the video blanking window is open, so active-display pixel lookups are never disturbed.

---
 rtl/pal_upload_if.sv | 11 +
 rtl/pal_upload.sv | 176 +++++++++++++++++
 tb/tb_pal_upload.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pal_upload_if.sv
// Entry stream into the palette uploader: one packed 15-bit RGB colour plus
// its palette index per transfer, with a valid/ready handshake.
interface pal_upload_if;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  IN_INDEX;
    logic [14:0] IN_RGB;

    modport master (output IN_VALID, output IN_INDEX, output IN_RGB, input IN_READY);
    modport slave  (input IN_VALID, input IN_INDEX, input IN_RGB, output IN_READY);
endinterface

// File: rtl/pal_upload.sv
// Palette RAM uploader: buffers RGB entries in a FIFO and writes each one as
// red/green/blue component writes on the chip's CPU port during blanking.
module pal_upload #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK_32M,
    input  logic        RESET_N,
    pal_upload_if.slave in_if,
    input  logic        WINDOW,
    output logic        G,
    output logic        MWR,
    output logic [19:1] A,
    output logic [15:0] DOUT,
    output logic        BUSY,
    output logic [15:0] WR_COUNT
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // FIFO entry layout: {index[7:0], rgb[14:0]}
    logic [22:0] fifo_mem_r [FIFO_DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        fifo_empty_s;
    logic        fifo_full_s;
    logic        push_s;
    logic        pop_s;
    logic [22:0] head_s;

    state_t      state_r;
    state_t      state_nx_s;
    logic [1:0]  comp_r;
    logic [1:0]  comp_nx_s;
    logic [22:0] ent_r;
    logic [22:0] ent_nx_s;
    logic        g_r;
    logic        g_nx_s;
    logic        mwr_r;
    logic        mwr_nx_s;
    logic [19:1] a_r;
    logic [19:1] a_nx_s;
    logic [15:0] dout_r;
    logic [15:0] dout_nx_s;
    logic [15:0] wr_count_r;
    logic [15:0] wr_count_nx_s;

    function automatic logic [19:1] addr_of(input logic [7:0] idx, input logic [1:0] comp);
        logic [19:1] addr;
        addr        = 19'd0;
        addr[8:1]   = idx;
        addr[11:10] = comp;
        return addr;
    endfunction

    function automatic logic [15:0] data_of(input logic [14:0] rgb, input logic [1:0] comp);
        logic [4:0] val;
        case (comp)
            2'd0:    val = rgb[4:0];
            2'd1:    val = rgb[9:5];
            2'd2:    val = rgb[14:10];
            default: val = 5'd0;
        endcase
        return {11'd0, val};
    endfunction

    assign fifo_empty_s    = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s     = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign in_if.IN_READY  = RESET_N & ~fifo_full_s;
    assign push_s          = in_if.IN_VALID & in_if.IN_READY;
    assign head_s          = fifo_mem_r[rd_ptr_r[AW-1:0]];

    assign G        = g_r;
    assign MWR      = mwr_r;
    assign A        = a_r;
    assign DOUT     = dout_r;
    assign WR_COUNT = wr_count_r;
    assign BUSY     = ~fifo_empty_s | (state_r != ST_IDLE);

    // FIFO storage; push_s already excludes reset and the full case
    always_ff @(posedge CLK_32M) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= {in_if.IN_INDEX, in_if.IN_RGB};
        end
    end

    // FIFO pointers; the in-flight entry stays at the head until its blue write
    always_ff @(posedge CLK_32M) begin
        if (!RESET_N) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Next state and next registered bus values; A/DOUT hold unless a SETUP begins
    always_comb begin
        state_nx_s    = state_r;
        comp_nx_s     = comp_r;
        ent_nx_s      = ent_r;
        g_nx_s        = 1'b0;
        mwr_nx_s      = 1'b0;
        a_nx_s        = a_r;
        dout_nx_s     = dout_r;
        wr_count_nx_s = wr_count_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && WINDOW) begin
                    state_nx_s = ST_SETUP;
                    comp_nx_s  = 2'd0;
                    ent_nx_s   = head_s;
                    g_nx_s     = 1'b1;
                    a_nx_s     = addr_of(head_s[22:15], 2'd0);
                    dout_nx_s  = data_of(head_s[14:0], 2'd0);
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nx_s = ST_WRITE;
                g_nx_s     = 1'b1;
                mwr_nx_s   = 1'b1;
            end
            ST_WRITE: begin
                if (comp_r != 2'd2) begin
                    state_nx_s = ST_SETUP;
                    comp_nx_s  = comp_r + 2'd1;
                    g_nx_s     = 1'b1;
                    a_nx_s     = addr_of(ent_r[22:15], comp_nx_s);
                    dout_nx_s  = data_of(ent_r[14:0], comp_nx_s);
                end else begin
                    state_nx_s    = ST_IDLE;
                    pop_s         = 1'b1;
                    wr_count_nx_s = wr_count_r + 16'd1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK_32M) begin
        if (!RESET_N) begin
            state_r    <= ST_IDLE;
            comp_r     <= 2'd0;
            ent_r      <= 23'd0;
            g_r        <= 1'b0;
            mwr_r      <= 1'b0;
            a_r        <= 19'd0;
            dout_r     <= 16'd0;
            wr_count_r <= 16'd0;
        end else begin
            state_r    <= state_nx_s;
            comp_r     <= comp_nx_s;
            ent_r      <= ent_nx_s;
            g_r        <= g_nx_s;
            mwr_r      <= mwr_nx_s;
            a_r        <= a_nx_s;
            dout_r     <= dout_nx_s;
            wr_count_r <= wr_count_nx_s;
        end
    end
endmodule

// File: tb/tb_pal_upload.sv
// Self-checking bench for pal_upload: random entries checked against a
// queue-based model of the expected red/green/blue write sequence.
module tb_pal_upload;
    localparam int DEPTH = 4;

    logic        CLK_32M = 1'b0;
    logic        RESET_N;
    logic        WINDOW;
    logic        G;
    logic        MWR;
    logic [19:1] A;
    logic [15:0] DOUT;
    logic        BUSY;
    logic [15:0] WR_COUNT;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        g_prev = 1'b0;
    logic [34:0] wr_q[$];     // observed strobes {A, DOUT}
    int          start_q[$];  // cycle numbers where G rose
    logic [22:0] exp_q[$];    // model: accepted entries {index, rgb} in order
    logic [15:0] exp_count;

    pal_upload_if bus ();

    pal_upload #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK_32M (CLK_32M),
        .RESET_N (RESET_N),
        .in_if   (bus),
        .WINDOW  (WINDOW),
        .G       (G),
        .MWR     (MWR),
        .A       (A),
        .DOUT    (DOUT),
        .BUSY    (BUSY),
        .WR_COUNT(WR_COUNT)
    );

    always #5 CLK_32M = ~CLK_32M;

    // bus monitor, sampled 1 time unit after each rising edge
    always @(posedge CLK_32M) begin
        #1;
        cyc = cyc + 1;
        if (G === 1'b1 && MWR === 1'b1) wr_q.push_back({A, DOUT});
        if (G === 1'b1 && g_prev !== 1'b1) start_q.push_back(cyc);
        g_prev = G;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // model: component c of entry e goes to address index + 512*c, data = 5-bit slice
    function automatic logic [34:0] exp_strobe(input logic [22:0] e, input int c);
        logic [18:0] a;
        logic [15:0] d;
        logic [14:0] rgb;
        rgb = e[14:0];
        a = 19'(e[22:15]) + 19'(c * 512);
        d = 16'((rgb >> (5 * c)) & 15'h1F);
        return {a, d};
    endfunction

    task automatic push(input logic [22:0] e, output bit ok);
        ok = 1'b0;
        @(negedge CLK_32M);
        bus.IN_VALID = 1'b1;
        bus.IN_INDEX = e[22:15];
        bus.IN_RGB   = e[14:0];
        for (int i = 0; i < 60; i++) begin
            if (bus.IN_READY === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK_32M);
        end
        if (ok) begin
            @(posedge CLK_32M);
            exp_q.push_back(e);
        end
        #1 bus.IN_VALID = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK_32M);
            if (BUSY === 1'b0 && G === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_logs();
        wr_q.delete();
        start_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; WINDOW = 1'b0;
        bus.IN_VALID = 1'b0; bus.IN_INDEX = 8'd0; bus.IN_RGB = 15'd0;
        repeat (3) @(posedge CLK_32M);
        @(negedge CLK_32M);
        checks++;
        if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b expected 0", bus.IN_READY); end
        checks++;
        if ({G, MWR, A, DOUT, WR_COUNT, BUSY} !== 54'd0) begin
            errors++; $display("FAIL rst_outputs: got G=%b MWR=%b A=%h DOUT=%h CNT=%h BUSY=%b expected all 0", G, MWR, A, DOUT, WR_COUNT, BUSY);
        end
        RESET_N = 1'b1;
        @(negedge CLK_32M);
        checks++;
        if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL rst_ready_high: got %b expected 1", bus.IN_READY); end
        exp_count = 16'd0;
        clear_logs();
    endtask

    task automatic test_single();
        logic [22:0] e;
        logic [36:0] want;
        bit ok;
        e = {8'h3C, 5'h15, 5'h0A, 5'h1F};
        WINDOW = 1'b1;
        push(e, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_push: got not accepted expected accepted"); end
        @(negedge CLK_32M);
        checks++;
        if (G !== 1'b0) begin errors++; $display("FAIL single_decide_g: got %b expected 0", G); end
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK_32M);
            want = {1'b1, 1'(k % 2), exp_strobe(e, k / 2)};
            checks++;
            if ({G, MWR, A, DOUT} !== want) begin
                errors++; $display("FAIL single_cycle%0d: got %h expected %h", k + 1, {G, MWR, A, DOUT}, want);
            end
        end
        @(negedge CLK_32M);
        exp_count = exp_count + 16'd1;
        checks++;
        if ({G, MWR, BUSY, WR_COUNT} !== {3'b000, exp_count}) begin
            errors++; $display("FAIL single_after: got G=%b MWR=%b BUSY=%b CNT=%h expected 0 0 0 %h", G, MWR, BUSY, WR_COUNT, exp_count);
        end
        checks++;
        if ({A, DOUT} !== {19'(8'h3C) + 19'd1024, 16'h0015}) begin
            errors++; $display("FAIL single_hold: got A=%h DOUT=%h expected hold of blue write", A, DOUT);
        end
        clear_logs();
    endtask

    task automatic test_window();
        bit ok;
        int g_seen;
        WINDOW = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push(23'($urandom), ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL win_push%0d: got not accepted expected accepted", i); end
        end
        g_seen = 0;
        repeat (20) begin @(negedge CLK_32M); if (G !== 1'b0) g_seen++; end
        checks++;
        if (g_seen != 0 || BUSY !== 1'b1) begin errors++; $display("FAIL win_closed: got g_cycles=%0d busy=%b expected 0 1", g_seen, BUSY); end
        wr_q.delete(); start_q.delete();
        WINDOW = 1'b1;
        wait_idle(80, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL win_drain: got timeout expected idle"); end
        checks++;
        if (start_q.size() != 2 || start_q[1] - start_q[0] != 7) begin
            errors++; $display("FAIL win_spacing: got starts=%0d gap=%0d expected 2 7", start_q.size(), (start_q.size() == 2) ? start_q[1] - start_q[0] : -1);
        end
        checks++;
        if (wr_q.size() != 3 * exp_q.size()) begin
            errors++; $display("FAIL win_strobe_count: got %0d expected %0d", wr_q.size(), 3 * exp_q.size());
        end else begin
            for (int i = 0; i < wr_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== exp_strobe(exp_q[i / 3], i % 3)) begin
                    errors++; $display("FAIL win_strobe%0d: got %h expected %h", i, wr_q[i], exp_strobe(exp_q[i / 3], i % 3));
                end
            end
        end
        exp_count = exp_count + 16'd2;
        checks++;
        if (WR_COUNT !== exp_count) begin errors++; $display("FAIL win_count: got %h expected %h", WR_COUNT, exp_count); end
        clear_logs();

        // window drops during the third cycle of the first entry
        WINDOW = 1'b0;
        push(23'($urandom), ok);
        push(23'($urandom), ok);
        wr_q.delete(); start_q.delete();
        @(negedge CLK_32M);
        WINDOW = 1'b1;
        for (int i = 0; i < 10; i++) begin @(negedge CLK_32M); if (G === 1'b1) break; end
        checks++;
        if (G !== 1'b1) begin errors++; $display("FAIL win_start: got G=%b expected 1", G); end
        repeat (2) @(negedge CLK_32M);
        WINDOW = 1'b0;
        repeat (20) @(negedge CLK_32M);
        checks++;
        if (start_q.size() != 1 || wr_q.size() != 3 || BUSY !== 1'b1) begin
            errors++; $display("FAIL win_drop: got starts=%0d strobes=%0d busy=%b expected 1 3 1", start_q.size(), wr_q.size(), BUSY);
        end
        for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_strobe(exp_q[0], i)) begin errors++; $display("FAIL win_drop_strobe%0d: got %h expected %h", i, wr_q[i], exp_strobe(exp_q[0], i)); end
        end
        exp_count = exp_count + 16'd1;
        checks++;
        if (WR_COUNT !== exp_count) begin errors++; $display("FAIL win_drop_count: got %h expected %h", WR_COUNT, exp_count); end
        void'(exp_q.pop_front());
        wr_q.delete();
        WINDOW = 1'b1;
        wait_idle(40, ok);
        checks++;
        if (!ok || wr_q.size() != 3 || wr_q[2] !== exp_strobe(exp_q[0], 2)) begin
            errors++; $display("FAIL win_second: got ok=%b strobes=%0d expected 1 3", ok, wr_q.size());
        end
        exp_count = exp_count + 16'd1;
        clear_logs();
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        int stuck;
        logic [22:0] e5;
        WINDOW = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push(23'($urandom), ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL bp_push%0d: got not accepted expected accepted", i); end
        end
        e5 = 23'($urandom);
        @(negedge CLK_32M);
        bus.IN_VALID = 1'b1; bus.IN_INDEX = e5[22:15]; bus.IN_RGB = e5[14:0];
        checks++;
        if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", bus.IN_READY); end
        stuck = 0;
        repeat (5) begin @(negedge CLK_32M); if (bus.IN_READY !== 1'b0) stuck++; end
        checks++;
        if (stuck != 0) begin errors++; $display("FAIL bp_hold: got ready-high cycles=%0d expected 0", stuck); end
        WINDOW = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin @(negedge CLK_32M); n = i; if (bus.IN_READY === 1'b1) break; end
        checks++;
        if (n != 7 || WR_COUNT !== exp_count + 16'd1) begin
            errors++; $display("FAIL bp_ready_rise: got cycle=%0d cnt=%h expected 7 %h", n, WR_COUNT, exp_count + 16'd1);
        end
        @(posedge CLK_32M);
        exp_q.push_back(e5);
        #1 bus.IN_VALID = 1'b0;
        wait_idle(100, ok);
        checks++;
        if (!ok || wr_q.size() != 3 * exp_q.size()) begin
            errors++; $display("FAIL bp_strobe_count: got %0d expected %0d", wr_q.size(), 3 * exp_q.size());
        end else begin
            for (int i = 0; i < wr_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== exp_strobe(exp_q[i / 3], i % 3)) begin
                    errors++; $display("FAIL bp_strobe%0d: got %h expected %h", i, wr_q[i], exp_strobe(exp_q[i / 3], i % 3));
                end
            end
        end
        exp_count = exp_count + 16'(DEPTH + 1);
        checks++;
        if (WR_COUNT !== exp_count) begin errors++; $display("FAIL bp_count: got %h expected %h", WR_COUNT, exp_count); end
        clear_logs();
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit pop_seen;
        logic prev_ready;
        logic [15:0] prev_cnt;
        logic [22:0] cur;
        int extra;
        int bad_gap;
        WINDOW = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(23'($urandom), ok);
        wr_q.delete(); start_q.delete();
        cur = 23'($urandom);
        bus.IN_VALID = 1'b1; bus.IN_INDEX = cur[22:15]; bus.IN_RGB = cur[14:0];
        WINDOW = 1'b1;
        extra = 0; pop_seen = 1'b0; prev_ready = 1'b0; prev_cnt = WR_COUNT;
        for (int i = 0; i < 300 && extra < 6; i++) begin
            @(negedge CLK_32M);
            if (!pop_seen && WR_COUNT !== prev_cnt) begin
                pop_seen = 1'b1;
                checks++;
                if ({prev_ready, bus.IN_READY} !== 2'b01) begin
                    errors++; $display("FAIL b2b_ready_after_pop: got before=%b after=%b expected 0 1", prev_ready, bus.IN_READY);
                end
            end
            prev_cnt = WR_COUNT;
            prev_ready = bus.IN_READY;
            if (bus.IN_READY === 1'b1) begin
                @(posedge CLK_32M);
                exp_q.push_back(cur);
                extra++;
                #1;
                cur = 23'($urandom);
                bus.IN_INDEX = cur[22:15]; bus.IN_RGB = cur[14:0];
                if (extra == 6) bus.IN_VALID = 1'b0;
            end
        end
        bus.IN_VALID = 1'b0;
        wait_idle(200, ok);
        checks++;
        if (!ok || extra != 6 || !pop_seen) begin errors++; $display("FAIL b2b_progress: got ok=%b pushed=%0d pop=%b expected 1 6 1", ok, extra, pop_seen); end
        bad_gap = 0;
        for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i - 1] != 7) bad_gap++;
        checks++;
        if (bad_gap != 0 || start_q.size() != DEPTH + 6) begin
            errors++; $display("FAIL b2b_spacing: got bad_gaps=%0d starts=%0d expected 0 %0d", bad_gap, start_q.size(), DEPTH + 6);
        end
        checks++;
        if (wr_q.size() != 3 * exp_q.size()) begin
            errors++; $display("FAIL b2b_strobe_count: got %0d expected %0d", wr_q.size(), 3 * exp_q.size());
        end else begin
            for (int i = 0; i < wr_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== exp_strobe(exp_q[i / 3], i % 3)) begin
                    errors++; $display("FAIL b2b_strobe%0d: got %h expected %h", i, wr_q[i], exp_strobe(exp_q[i / 3], i % 3));
                end
            end
        end
        exp_count = exp_count + 16'(DEPTH + 6);
        checks++;
        if (WR_COUNT !== exp_count) begin errors++; $display("FAIL b2b_count: got %h expected %h", WR_COUNT, exp_count); end
        clear_logs();
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [22:0] e;
        e = 23'($urandom);
        WINDOW = 1'b1;
        push(e, ok);
        for (int i = 0; i < 10; i++) begin @(negedge CLK_32M); if (G === 1'b1) break; end
        repeat (3) @(negedge CLK_32M);
        checks++;
        if (MWR !== 1'b1 || A[11:10] !== 2'd1) begin errors++; $display("FAIL mid_green_write: got MWR=%b comp=%0d expected 1 1", MWR, A[11:10]); end
        RESET_N = 1'b0;
        @(negedge CLK_32M);
        checks++;
        if ({G, MWR, A, DOUT, WR_COUNT, BUSY} !== 54'd0) begin
            errors++; $display("FAIL mid_reset: got G=%b MWR=%b A=%h DOUT=%h CNT=%h BUSY=%b expected all 0", G, MWR, A, DOUT, WR_COUNT, BUSY);
        end
        RESET_N = 1'b1;
        exp_count = 16'd0;
        repeat (12) @(negedge CLK_32M);
        checks++;
        if (wr_q.size() != 2 || start_q.size() != 1 || BUSY !== 1'b0) begin
            errors++; $display("FAIL mid_no_blue: got strobes=%0d starts=%0d busy=%b expected 2 1 0", wr_q.size(), start_q.size(), BUSY);
        end
        clear_logs();
        e = 23'($urandom);
        push(e, ok);
        wait_idle(40, ok);
        checks++;
        if (!ok || wr_q.size() != 3) begin errors++; $display("FAIL mid_fresh_count: got ok=%b strobes=%0d expected 1 3", ok, wr_q.size()); end
        for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_strobe(e, i)) begin errors++; $display("FAIL mid_fresh%0d: got %h expected %h", i, wr_q[i], exp_strobe(e, i)); end
        end
        exp_count = exp_count + 16'd1;
        checks++;
        if (WR_COUNT !== exp_count) begin errors++; $display("FAIL mid_fresh_cnt: got %h expected %h", WR_COUNT, exp_count); end
        clear_logs();
    endtask

    task automatic test_wrap();
        bit ok;
        @(negedge CLK_32M);
        force dut.wr_count_r = 16'hFFFE;
        @(negedge CLK_32M);
        release dut.wr_count_r;
        exp_count = 16'hFFFE;
        @(negedge CLK_32M);
        checks++;
        if (WR_COUNT !== exp_count) begin errors++; $display("FAIL wrap_preload: got %h expected %h", WR_COUNT, exp_count); end
        WINDOW = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push(23'($urandom), ok);
            wait_idle(40, ok);
            exp_count = exp_count + 16'd1;
            checks++;
            if (WR_COUNT !== exp_count) begin errors++; $display("FAIL wrap_step%0d: got %h expected %h", i, WR_COUNT, exp_count); end
        end
        checks++;
        if (WR_COUNT !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", WR_COUNT); end
        clear_logs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_window();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
